// File: rtl/seg7_scan_ctrl.sv
// Scan scheduler for a 4-digit multiplexed 7-segment display.
// Time-shares the segment bus across four digits, decodes hex nibbles,
// inserts an all-deselected guard at the start of every digit slot,
// applies PWM brightness and leading-zero suppression, and swaps in new
// display data only at frame boundaries so a frame never mixes old and new digits.
//
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_value[15:0]     four hex nibbles, [3:0] = digit0 (rightmost)
//   i_dp[3:0]         decimal point per digit, 1 = lit
//   i_blank[3:0]      per-digit blank, 1 = dark (segments and dp)
//   i_lzs             leading-zero suppression enable
//   i_bright[3:0]     brightness, duty = (i_bright+1)/16 of post-guard slot (live)
//   i_load            capture request for value/dp/blank/lzs
//   o_load_ack        1-cycle pulse when captured data becomes visible
//   o_frame           1-cycle pulse as the digit0 slot begins
//   o_seg7[6:0]       segments {g,f,e,d,c,b,a}, active-low
//   o_dp              decimal point, active-low
//   o_seg7_nSel[3:0]  digit select, active-low, at most one bit low
module seg7_scan_ctrl #(
    parameter int unsigned SCAN_DIV = 4096,
    parameter int unsigned GUARD    = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [15:0] i_value,
    input  logic [3:0]  i_dp,
    input  logic [3:0]  i_blank,
    input  logic        i_lzs,
    input  logic [3:0]  i_bright,
    input  logic        i_load,
    output logic        o_load_ack,
    output logic        o_frame,
    output logic [6:0]  o_seg7,
    output logic        o_dp,
    output logic [3:0]  o_seg7_nSel
);

    localparam int unsigned CNT_W = $clog2(SCAN_DIV);

    typedef struct packed {
        logic [15:0] value;
        logic [3:0]  dp;
        logic [3:0]  blank;
        logic        lzs;
    } disp_t;

    localparam disp_t DISP_RESET = '{value: 16'h0000, dp: 4'h0, blank: 4'hF, lzs: 1'b0};

    logic [CNT_W-1:0] slot_cnt;
    logic [1:0]       digit;
    logic             pending;
    disp_t            shadow;
    disp_t            visible;

    disp_t            load_in;
    logic             slot_wrap;
    logic             frame_wrap;
    logic [3:0]       pwm;
    logic             lit;
    logic [3:0]       nibble;
    logic             suppress;
    logic [6:0]       seg_nxt;
    logic             dp_nxt;
    logic [3:0]       nsel_nxt;

    // Active-low hex segment patterns {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Capture bundle and scan position decode.
    always_comb begin
        load_in.value = i_value;
        load_in.dp    = i_dp;
        load_in.blank = i_blank;
        load_in.lzs   = i_lzs;
        slot_wrap     = (slot_cnt == CNT_W'(SCAN_DIV - 1));
        frame_wrap    = slot_wrap && (digit == 2'd3);
        pwm           = slot_cnt[CNT_W-1 -: 4];
        lit           = (slot_cnt >= CNT_W'(GUARD)) && (pwm <= i_bright);
        nibble        = visible.value[{digit, 2'b00} +: 4];
    end

    // A digit is suppressed when it and every higher nibble are zero; digit0 never.
    always_comb begin
        logic z3, z2, z1;
        z3       = (visible.value[15:12] == 4'h0);
        z2       = z3 && (visible.value[11:8] == 4'h0);
        z1       = z2 && (visible.value[7:4] == 4'h0);
        suppress = 1'b0;
        case (digit)
            2'd3:    suppress = z3;
            2'd2:    suppress = z2;
            2'd1:    suppress = z1;
            default: suppress = 1'b0;
        endcase
        suppress = suppress && visible.lzs;
    end

    // Next pin values; a blanked digit is also deselected so it stays fully dark.
    always_comb begin
        seg_nxt  = 7'h7F;
        dp_nxt   = 1'b1;
        nsel_nxt = 4'hF;
        if (lit && !visible.blank[digit]) begin
            nsel_nxt = ~(4'b0001 << digit);
            dp_nxt   = ~visible.dp[digit];
            seg_nxt  = suppress ? 7'h7F : hex_to_seg(nibble);
        end
    end

    // Scan counters, load handshake and registered pins.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            slot_cnt    <= '0;
            digit       <= 2'd0;
            pending     <= 1'b0;
            shadow      <= DISP_RESET;
            visible     <= DISP_RESET;
            o_load_ack  <= 1'b0;
            o_frame     <= 1'b0;
            o_seg7      <= 7'h7F;
            o_dp        <= 1'b1;
            o_seg7_nSel <= 4'hF;
        end else begin
            slot_cnt    <= slot_cnt + CNT_W'(1);
            o_frame     <= frame_wrap;
            o_load_ack  <= 1'b0;
            o_seg7      <= seg_nxt;
            o_dp        <= dp_nxt;
            o_seg7_nSel <= nsel_nxt;
            if (slot_wrap) begin
                digit <= digit + 2'd1;
            end
            if (i_load) begin
                shadow  <= load_in;
                pending <= 1'b1;
            end
            // A load on the boundary cycle itself bypasses the shadow.
            if (frame_wrap) begin
                pending    <= 1'b0;
                o_load_ack <= i_load || pending;
                if (i_load) begin
                    visible <= load_in;
                end else if (pending) begin
                    visible <= shadow;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with SCAN_DIV=64, GUARD=2 (frame = 256 clocks).
module tb_seg7_scan_ctrl;

    logic        clk;
    logic        rst;
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic        lzs;
    logic [3:0]  bright;
    logic        load;
    logic        load_ack;
    logic        frame;
    logic [6:0]  seg7;
    logic        seg_dp;
    logic [3:0]  nsel;

    int checks = 0;
    int errors = 0;

    seg7_scan_ctrl #(.SCAN_DIV(64), .GUARD(2)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_value     (value),
        .i_dp        (dp),
        .i_blank     (blank),
        .i_lzs       (lzs),
        .i_bright    (bright),
        .i_load      (load),
        .o_load_ack  (load_ack),
        .o_frame     (frame),
        .o_seg7      (seg7),
        .o_dp        (seg_dp),
        .o_seg7_nSel (nsel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string       name;
        logic [15:0] value;
        logic [3:0]  dp;
        logic [3:0]  blank;
        logic        lzs;
        logic [3:0]  bright;
        int          pos;    // clock offset from the start of the applied frame
        logic [6:0]  seg;
        logic        sdp;
        logic [3:0]  nsel;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string nm, logic [15:0] v, logic [3:0] d, logic [3:0] b,
                                logic l, logic [3:0] br, int p,
                                logic [6:0] s, logic sd, logic [3:0] ns);
        vec_t r;
        r.name = nm; r.value = v; r.dp = d; r.blank = b; r.lzs = l; r.bright = br;
        r.pos = p; r.seg = s; r.sdp = sd; r.nsel = ns;
        return r;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    // Waits (from the current negedge) for an ack pulse, bounded.
    task automatic wait_ack(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (load_ack) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_frame(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (frame) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic drive(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b,
                         input logic l, input logic [3:0] br);
        value = v; dp = d; blank = b; lzs = l; bright = br;
    endtask

    task automatic pulse_load;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    initial begin
        bit ok;
        int n;
        int bad;
        int cnt_e, cnt_d, cnt_b, cnt_7, acks;

        rst = 1'b1; load = 1'b0;
        drive(16'h0000, 4'h0, 4'h0, 1'b0, 4'hF);

        // Table: {inputs, frame position, expected seg/dp/nSel}.
        vecs.push_back(mk("t2_d0",     16'h12AF, 4'h0, 4'h0, 1'b0, 4'hF,   5, 7'h0E, 1'b1, 4'hE));
        vecs.push_back(mk("t2_d1",     16'h12AF, 4'h0, 4'h0, 1'b0, 4'hF,  74, 7'h08, 1'b1, 4'hD));
        vecs.push_back(mk("t2_d2_end", 16'h12AF, 4'h0, 4'h0, 1'b0, 4'hF, 191, 7'h24, 1'b1, 4'hB));
        vecs.push_back(mk("t2_d3",     16'h12AF, 4'h0, 4'h0, 1'b0, 4'hF, 194, 7'h79, 1'b1, 4'h7));
        vecs.push_back(mk("guard_d0",  16'h12AF, 4'h0, 4'h0, 1'b0, 4'hF,   0, 7'h7F, 1'b1, 4'hF));
        vecs.push_back(mk("guard_d1",  16'h12AF, 4'h0, 4'h0, 1'b0, 4'hF,  65, 7'h7F, 1'b1, 4'hF));
        vecs.push_back(mk("lzs_d3",    16'h0050, 4'h0, 4'h0, 1'b1, 4'hF, 212, 7'h7F, 1'b1, 4'h7));
        vecs.push_back(mk("lzs_d2",    16'h0050, 4'h0, 4'h0, 1'b1, 4'hF, 148, 7'h7F, 1'b1, 4'hB));
        vecs.push_back(mk("lzs_d1",    16'h0050, 4'h0, 4'h0, 1'b1, 4'hF,  84, 7'h12, 1'b1, 4'hD));
        vecs.push_back(mk("lzs_d0",    16'h0050, 4'h0, 4'h0, 1'b1, 4'hF,  20, 7'h40, 1'b1, 4'hE));
        vecs.push_back(mk("nolzs_d3",  16'h0050, 4'h0, 4'h0, 1'b0, 4'hF, 212, 7'h40, 1'b1, 4'h7));
        vecs.push_back(mk("nolzs_d2",  16'h0050, 4'h0, 4'h0, 1'b0, 4'hF, 148, 7'h40, 1'b1, 4'hB));
        vecs.push_back(mk("br3_lit",   16'h12AF, 4'h0, 4'h0, 1'b0, 4'h3,  15, 7'h0E, 1'b1, 4'hE));
        vecs.push_back(mk("br3_dark",  16'h12AF, 4'h0, 4'h0, 1'b0, 4'h3,  16, 7'h7F, 1'b1, 4'hF));
        vecs.push_back(mk("br3_d1",    16'h12AF, 4'h0, 4'h0, 1'b0, 4'h3,  66, 7'h08, 1'b1, 4'hD));
        vecs.push_back(mk("br0_lit",   16'h12AF, 4'h0, 4'h0, 1'b0, 4'h0,   3, 7'h0E, 1'b1, 4'hE));
        vecs.push_back(mk("br0_dark",  16'h12AF, 4'h0, 4'h0, 1'b0, 4'h0,   4, 7'h7F, 1'b1, 4'hF));
        vecs.push_back(mk("dp_d2",     16'h12AF, 4'h4, 4'h1, 1'b0, 4'hF, 138, 7'h24, 1'b0, 4'hB));
        vecs.push_back(mk("blank_d0",  16'h12AF, 4'h4, 4'h1, 1'b0, 4'hF,  10, 7'h7F, 1'b1, 4'hF));
        vecs.push_back(mk("dp_d1_off", 16'h12AF, 4'h4, 4'h1, 1'b0, 4'hF,  74, 7'h08, 1'b1, 4'hD));
        vecs.push_back(mk("dec_E",     16'hBCDE, 4'h0, 4'h0, 1'b0, 4'hF,  10, 7'h06, 1'b1, 4'hE));
        vecs.push_back(mk("dec_D",     16'hBCDE, 4'h0, 4'h0, 1'b0, 4'hF,  74, 7'h21, 1'b1, 4'hD));
        vecs.push_back(mk("dec_C",     16'hBCDE, 4'h0, 4'h0, 1'b0, 4'hF, 138, 7'h46, 1'b1, 4'hB));
        vecs.push_back(mk("dec_B",     16'hBCDE, 4'h0, 4'h0, 1'b0, 4'hF, 202, 7'h03, 1'b1, 4'h7));
        vecs.push_back(mk("dec_9",     16'h6789, 4'h0, 4'h0, 1'b0, 4'hF,  10, 7'h10, 1'b1, 4'hE));
        vecs.push_back(mk("dec_8",     16'h6789, 4'h0, 4'h0, 1'b0, 4'hF,  74, 7'h00, 1'b1, 4'hD));
        vecs.push_back(mk("dec_7",     16'h6789, 4'h0, 4'h0, 1'b0, 4'hF, 138, 7'h78, 1'b1, 4'hB));
        vecs.push_back(mk("dec_6",     16'h6789, 4'h0, 4'h0, 1'b0, 4'hF, 202, 7'h02, 1'b1, 4'h7));
        vecs.push_back(mk("lzs_top4",  16'h4000, 4'h0, 4'h0, 1'b1, 4'hF, 202, 7'h19, 1'b1, 4'h7));
        vecs.push_back(mk("lzs_mid0",  16'h4000, 4'h0, 4'h0, 1'b1, 4'hF, 138, 7'h40, 1'b1, 4'hB));
        vecs.push_back(mk("lzs_dp3",   16'h0000, 4'h8, 4'h0, 1'b1, 4'hF, 202, 7'h7F, 1'b0, 4'h7));
        vecs.push_back(mk("lzs_zero0", 16'h0000, 4'h8, 4'h0, 1'b1, 4'hF,  10, 7'h40, 1'b1, 4'hE));

        // Reset state and idle scanning.
        repeat (3) @(negedge clk);
        check("rst_nsel", 32'(nsel), 32'hF);
        check("rst_seg", 32'(seg7), 32'h7F);
        check("rst_dp", 32'(seg_dp), 32'h1);
        check("rst_ack", 32'(load_ack), 32'h0);
        check("rst_frame", 32'(frame), 32'h0);
        rst = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame && n < 400);
        check("first_frame_clk", 32'(n), 32'd256);
        n = 0; bad = 0;
        do begin
            @(negedge clk);
            n++;
            if (nsel !== 4'hF || seg7 !== 7'h7F || seg_dp !== 1'b1) bad++;
        end while (!frame && n < 400);
        check("frame_period", 32'(n), 32'd256);
        check("idle_dark_cycles", 32'(bad), 32'd0);

        // Table-driven vectors.
        foreach (vecs[i]) begin
            drive(vecs[i].value, vecs[i].dp, vecs[i].blank, vecs[i].lzs, vecs[i].bright);
            pulse_load();
            wait_ack(ok);
            check({vecs[i].name, "_ack"}, 32'(ok), 32'h1);
            repeat (vecs[i].pos + 1) @(negedge clk);
            check({vecs[i].name, "_seg"}, 32'(seg7), 32'(vecs[i].seg));
            check({vecs[i].name, "_dp"}, 32'(seg_dp), 32'(vecs[i].sdp));
            check({vecs[i].name, "_nsel"}, 32'(nsel), 32'(vecs[i].nsel));
        end

        // Each digit selected for 62 of 64 clocks at full brightness.
        drive(16'h12AF, 4'h0, 4'h0, 1'b0, 4'hF);
        pulse_load();
        wait_ack(ok);
        check("duty_ack", 32'(ok), 32'h1);
        check("ack_with_frame", 32'(frame), 32'h1);
        cnt_e = 0; cnt_d = 0; cnt_b = 0; cnt_7 = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            case (nsel)
                4'hE: cnt_e++;
                4'hD: cnt_d++;
                4'hB: cnt_b++;
                4'h7: cnt_7++;
                default: ;
            endcase
        end
        check("sel_cnt_d0", 32'(cnt_e), 32'd62);
        check("sel_cnt_d1", 32'(cnt_d), 32'd62);
        check("sel_cnt_d2", 32'(cnt_b), 32'd62);
        check("sel_cnt_d3", 32'(cnt_7), 32'd62);

        // Three loads in one frame: newest wins, single ack.
        wait_frame(ok);
        check("multi_frame_seen", 32'(ok), 32'h1);
        repeat (3) @(negedge clk);
        drive(16'h0001, 4'h0, 4'h0, 1'b0, 4'hF); pulse_load();
        repeat (10) @(negedge clk);
        drive(16'h0002, 4'h0, 4'h0, 1'b0, 4'hF); pulse_load();
        repeat (10) @(negedge clk);
        drive(16'h0003, 4'h0, 4'h0, 1'b0, 4'hF); pulse_load();
        drive(16'hFFFF, 4'h0, 4'h0, 1'b0, 4'hF);
        wait_ack(ok);
        check("multi_ack", 32'(ok), 32'h1);
        repeat (6) @(negedge clk);
        check("multi_newest_seg", 32'(seg7), 32'h30);
        acks = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (load_ack) acks++;
        end
        check("multi_extra_acks", 32'(acks), 32'd0);

        // Load asserted on the boundary cycle is applied at that boundary.
        wait_frame(ok);
        check("bnd_frame_seen", 32'(ok), 32'h1);
        repeat (255) @(negedge clk);
        drive(16'h000A, 4'h0, 4'h0, 1'b0, 4'hF);
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        check("bnd_ack", 32'(load_ack), 32'h1);
        check("bnd_frame", 32'(frame), 32'h1);
        repeat (6) @(negedge clk);
        check("bnd_seg", 32'(seg7), 32'h08);

        // Reset while pending: no ack, display dark.
        wait_frame(ok);
        check("rstp_frame_seen", 32'(ok), 32'h1);
        drive(16'h0008, 4'h0, 4'h0, 1'b0, 4'hF);
        pulse_load();
        repeat (20) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        acks = 0; bad = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (load_ack) acks++;
            if (nsel !== 4'hF || seg7 !== 7'h7F) bad++;
        end
        check("rstp_no_ack", 32'(acks), 32'd0);
        check("rstp_dark", 32'(bad), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
